// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state
// encoding, legal prescale values and the 3-sample majority vote.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Resolved bit value from three samples taken around the bit centre.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with registered occupancy count. A push is
// accepted when there is room, or when the full FIFO is popped in the
// same cycle. The head word reads as zero while the FIFO is empty.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; empty gating on rdata
  // hides stale contents, and a resettable array would not map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, edge/bit counters,
// 3-sample majority vote, frame FSM, error pulses and a receive FIFO.
// Optional feature macro: UART_RX_BREAK_DET_EN (break detection and the
// BREAK state). Without it brk_det is tied low.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STP2_EN,
  input  logic [5:0]            prescale,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  overrun,
  output logic                  brk_det
);

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_START  = S_START;
  localparam logic [2:0] ST_DATA   = S_DATA;
  localparam logic [2:0] ST_PARITY = S_PARITY;
  localparam logic [2:0] ST_STOP   = S_STOP;
`ifdef UART_RX_BREAK_DET_EN
  localparam logic [2:0] ST_BREAK  = S_BREAK;
`endif
  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);

  logic                  sync1, rx_s, rx_prev;
  logic [2:0]            state;
  logic [5:0]            p_lat;
  logic [5:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  par_en_l, par_typ_l, stp2_l;
  logic                  s0, s1;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_flag;
`ifdef UART_RX_BREAK_DET_EN
  logic                  par_bit;
`endif

  logic [5:0] half, samp_a, samp_b, samp_c;
  logic       wrap, active, at_resolve, resolved, fall;
  logic       frame_end, brk_hit, push_req;
  logic       fifo_full, fifo_empty;

  // Sample points, bit resolution and frame-end decode.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    half       = '0;
    samp_a     = '0;
    samp_b     = '0;
    samp_c     = '0;
    wrap       = 1'b0;
    active     = 1'b0;
    at_resolve = 1'b0;
    resolved   = 1'b0;
    fall       = 1'b0;
    frame_end  = 1'b0;
    brk_hit    = 1'b0;
    push_req   = 1'b0;

    half       = {1'b0, p_lat[5:1]};
    samp_a     = half - 6'd1;
    samp_b     = half;
    samp_c     = half + 6'd1;
    wrap       = (edge_cnt == p_lat - 6'd1);
    active     = (state == ST_START) || (state == ST_DATA) ||
                 (state == ST_PARITY) || (state == ST_STOP);
    at_resolve = active && (edge_cnt == samp_c);
    resolved   = maj3(s0, s1, rx_s);
    fall       = rx_prev && !rx_s;
    // A frame ends on the first stop bit that resolves low, or on the
    // last stop bit otherwise.
    frame_end  = (state == ST_STOP) && at_resolve &&
                 (!resolved || !stp2_l || bit_cnt[0]);
`ifdef UART_RX_BREAK_DET_EN
    brk_hit    = frame_end && !resolved && (bit_cnt == 4'd0) &&
                 (shreg == '0) && (!par_en_l || !par_bit);
`endif
    push_req   = frame_end && resolved && !par_flag;
  end

  // Two-flop synchroniser plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= RX_IN;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // Capture the first two votes; the third is rx_s at the resolve edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (edge_cnt == samp_a) s0 <= rx_s;
      if (edge_cnt == samp_b) s1 <= rx_s;
    end
  end

  // Frame FSM with edge and bit counters; config is frozen at the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      p_lat     <= PRESCALE_16;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      stp2_l    <= 1'b0;
      shreg     <= '0;
      par_flag  <= 1'b0;
    end else begin
      if (active) edge_cnt <= wrap ? 6'd0 : edge_cnt + 6'd1;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            // Anything other than a legal prescale falls back to 16.
            p_lat     <= (prescale == PRESCALE_8 || prescale == PRESCALE_16 ||
                          prescale == PRESCALE_32) ? prescale : PRESCALE_16;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            stp2_l    <= STP2_EN;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            par_flag  <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (at_resolve && resolved) begin
            state <= ST_IDLE;
          end else if (wrap) begin
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (at_resolve) shreg <= {resolved, shreg[DATA_WIDTH-1:1]};
          if (wrap) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_l ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (at_resolve) par_flag <= ((^shreg) ^ resolved) != par_typ_l;
          if (wrap) begin
            bit_cnt <= '0;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (frame_end) begin
`ifdef UART_RX_BREAK_DET_EN
            state <= brk_hit ? ST_BREAK : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end else if (wrap) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Remember the received parity bit; only break qualification needs it.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (state == ST_PARITY && at_resolve) begin
      par_bit <= resolved;
    end
  end

  // Break pulse replaces the stop error for an all-zero frame.
  always_ff @(posedge clk) begin
    if (rst) brk_det <= 1'b0;
    else     brk_det <= brk_hit;
  end
`else
  assign brk_det = 1'b0;
`endif

  // Registered one-cycle error pulses, aligned with push visibility.
  always_ff @(posedge clk) begin
    if (rst) begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      strt_glitch <= (state == ST_START) && at_resolve && resolved;
      par_err     <= frame_end && par_flag && !brk_hit;
      stp_err     <= frame_end && !resolved && !brk_hit;
      overrun     <= push_req && fifo_full && !rx_ready;
    end
  end

  uart_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (shreg),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8-bit instance (a) and a 7-bit
// instance (b). Expected words are queued when frames are sent; a negedge
// monitor per instance pops and compares on each handshake and counts
// error-pulse cycles, which are compared against expected totals.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       par_en, par_typ, stp2_en;
  logic [5:0] prescale;
  logic       rx_ready;

  logic [7:0] rx_data_a;
  logic       rx_valid_a, par_err_a, stp_err_a, strt_glitch_a, overrun_a, brk_det_a;
  logic [6:0] rx_data_b;
  logic       rx_valid_b, par_err_b, stp_err_b, strt_glitch_b, overrun_b, brk_det_b;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .RX_IN(rx_a), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STP2_EN(stp2_en), .prescale(prescale), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready), .par_err(par_err_a),
    .stp_err(stp_err_a), .strt_glitch(strt_glitch_a), .overrun(overrun_a),
    .brk_det(brk_det_a));

  uart_rx_param #(.DATA_WIDTH(7), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .RX_IN(rx_b), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STP2_EN(stp2_en), .prescale(prescale), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready), .par_err(par_err_b),
    .stp_err(stp_err_b), .strt_glitch(strt_glitch_b), .overrun(overrun_b),
    .brk_det(brk_det_b));

  int total = 0;
  int bad   = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  // Observed pulse-cycle counts and expected totals: index 0 = a, 1 = b.
  int par_c[2], stp_c[2], glt_c[2], ovr_c[2], brk_c[2];
  int par_e[2], stp_e[2], glt_e[2], ovr_e[2], brk_e[2];
  int vcyc_a;

  logic       hold_a, hold_b;
  logic [7:0] held_a;
  logic [6:0] held_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor for instance a.
  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
    end else begin
      if (par_err_a)     par_c[0]++;
      if (stp_err_a)     stp_c[0]++;
      if (strt_glitch_a) glt_c[0]++;
      if (overrun_a)     ovr_c[0]++;
      if (brk_det_a)     brk_c[0]++;
      if (rx_valid_a)    vcyc_a++;
      if (hold_a && rx_valid_a) check("a_data_stable", 32'(rx_data_a), 32'(held_a));
      if (rx_valid_a && rx_ready) begin
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_extra_word: got %0h, want no word", rx_data_a);
        end else begin
          check("a_word", 32'(rx_data_a), 32'(q_a.pop_front()));
        end
      end
      hold_a = rx_valid_a && !rx_ready;
      held_a = rx_data_a;
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (rst) begin
      hold_b = 1'b0;
    end else begin
      if (par_err_b)     par_c[1]++;
      if (stp_err_b)     stp_c[1]++;
      if (strt_glitch_b) glt_c[1]++;
      if (overrun_b)     ovr_c[1]++;
      if (brk_det_b)     brk_c[1]++;
      if (hold_b && rx_valid_b) check("b_data_stable", 32'(rx_data_b), 32'(held_b));
      if (rx_valid_b && rx_ready) begin
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_extra_word: got %0h, want no word", rx_data_b);
        end else begin
          check("b_word", 32'(rx_data_b), 32'(q_b.pop_front()));
        end
      end
      hold_b = rx_valid_b && !rx_ready;
      held_b = rx_data_b;
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Send one frame; glitch_at inverts the line for that single cycle index.
  task automatic send(input bit sel, input int nbits, input logic [8:0] data,
                      input bit par_on, input logic par_val, input int nstop,
                      input logic stop_val, input int p, input int glitch_at);
    logic bits[$];
    int   cyc = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (par_on) bits.push_back(par_val);
    bits.push_back(stop_val);
    for (int i = 1; i < nstop; i++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        drive(sel, (cyc == glitch_at) ? ~bits[k] : bits[k]);
        cyc++;
      end
    end
    @(negedge clk);
    drive(sel, 1'b1);
  endtask

  task automatic config_line(input logic pe, input logic pt, input logic s2, input logic [5:0] p);
    @(posedge clk);
    #1;
    par_en   = pe;
    par_typ  = pt;
    stp2_en  = s2;
    prescale = p;
  endtask

  task automatic drain(input bit sel, input int limit);
    int n = 0;
    while (n < limit && (sel ? (q_b.size() != 0 || rx_valid_b)
                             : (q_a.size() != 0 || rx_valid_a))) begin
      @(posedge clk);
      n++;
    end
    if (sel ? (q_b.size() != 0 || rx_valid_b) : (q_a.size() != 0 || rx_valid_a)) begin
      total++;
      bad++;
      $display("FAIL drain_timeout_%0d: got %0d queued, want 0", sel, sel ? q_b.size() : q_a.size());
    end
  endtask

  task automatic check_errs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_par_err_%0d", tag, i),     32'(par_c[i]), 32'(par_e[i]));
      check($sformatf("%s_stp_err_%0d", tag, i),     32'(stp_c[i]), 32'(stp_e[i]));
      check($sformatf("%s_strt_glitch_%0d", tag, i), 32'(glt_c[i]), 32'(glt_e[i]));
      check($sformatf("%s_overrun_%0d", tag, i),     32'(ovr_c[i]), 32'(ovr_e[i]));
      check($sformatf("%s_brk_det_%0d", tag, i),     32'(brk_c[i]), 32'(brk_e[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      par_c[i] = 0; stp_c[i] = 0; glt_c[i] = 0; ovr_c[i] = 0; brk_c[i] = 0;
      par_e[i] = 0; stp_e[i] = 0; glt_e[i] = 0; ovr_e[i] = 0; brk_e[i] = 0;
    end
    vcyc_a   = 0;
    rst      = 1'b1;
    rx_a     = 1'b1;
    rx_b     = 1'b1;
    rx_ready = 1'b1;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    stp2_en  = 1'b0;
    prescale = 6'd8;
    repeat (4) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("reset_rx_valid_a", 32'(rx_valid_a), 32'd0);
    check("reset_rx_data_a", 32'(rx_data_a), 32'd0);
    check("reset_pulses_a", {27'd0, par_err_a, stp_err_a, strt_glitch_a, overrun_a, brk_det_a}, 32'd0);
    check("reset_rx_valid_b", 32'(rx_valid_b), 32'd0);
    check("reset_rx_data_b", 32'(rx_data_b), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // 0xA5, prescale 8, no parity, one stop, ready high: one valid cycle.
    config_line(1'b0, 1'b0, 1'b0, 6'd8);
    q_a.push_back(9'h0A5);
    send(1'b0, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1, 8, -1);
    drain(1'b0, 200);
    repeat (8) @(posedge clk);
    check("a5_valid_cycles", 32'(vcyc_a), 32'd1);
    check_errs("a5");

    // 7-bit, prescale 16, odd parity, two stops: wrong parity, then correct.
    config_line(1'b1, 1'b1, 1'b1, 6'd16);
    send(1'b1, 7, 9'h041, 1'b1, 1'b0, 2, 1'b1, 16, -1);
    par_e[1]++;
    repeat (8) @(posedge clk);
    check("par_bad_no_push", 32'(rx_valid_b), 32'd0);
    q_b.push_back(9'h041);
    send(1'b1, 7, 9'h041, 1'b1, 1'b1, 2, 1'b1, 16, -1);
    drain(1'b1, 400);
    repeat (4) @(posedge clk);
    check_errs("par");

    // Prescale 32, even parity, first stop low: stop error; then clean frame.
    config_line(1'b1, 1'b0, 1'b0, 6'd32);
    send(1'b0, 8, 9'h05A, 1'b1, 1'b0, 1, 1'b0, 32, -1);
    stp_e[0]++;
    repeat (40) @(posedge clk);
    check("stp_bad_no_push", 32'(rx_valid_a), 32'd0);
    q_a.push_back(9'h05A);
    send(1'b0, 8, 9'h05A, 1'b1, 1'b0, 1, 1'b1, 32, -1);
    drain(1'b0, 600);
    repeat (4) @(posedge clk);
    check_errs("stp");

    // Three-clock low pulse at prescale 16: start glitch, nothing pushed.
    config_line(1'b0, 1'b0, 1'b0, 6'd16);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      rx_a = 1'b0;
    end
    @(negedge clk);
    rx_a = 1'b1;
    glt_e[0]++;
    repeat (40) @(posedge clk);
    check("glitch_no_push", 32'(rx_valid_a), 32'd0);
    check_errs("glt");

    // Ready low, five back-to-back frames into a 4-deep FIFO: overrun on 5th.
    config_line(1'b0, 1'b0, 1'b0, 6'd8);
    @(posedge clk);
    #1 rx_ready = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      if (f <= 4) q_a.push_back(9'(f));
      send(1'b0, 8, 9'(f), 1'b0, 1'b0, 1, 1'b1, 8, -1);
    end
    ovr_e[0]++;
    repeat (10) @(posedge clk);
    check("ovr_valid_held", 32'(rx_valid_a), 32'd1);
    check("ovr_head_word", 32'(rx_data_a), 32'h01);
    check_errs("ovr");
    @(posedge clk);
    #1 rx_ready = 1'b1;
    drain(1'b0, 50);

    // Glitch high for one clock at the middle sample of data bit 3 (P=8).
    q_a.push_back(9'h000);
    send(1'b0, 8, 9'h000, 1'b0, 1'b0, 1, 1'b1, 8, 4 * 8 + 4 + 1);
    drain(1'b0, 200);
    repeat (4) @(posedge clk);
    check_errs("vote");

    // Break: line low for 20 bit times, then a normal frame.
    @(negedge clk);
    rx_a = 1'b0;
    repeat (20 * 8) @(negedge clk);
    rx_a = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
    brk_e[0]++;
`else
    stp_e[0]++;
`endif
    repeat (24) @(posedge clk);
    check("brk_no_push", 32'(rx_valid_a), 32'd0);
    q_a.push_back(9'h03C);
    send(1'b0, 8, 9'h03C, 1'b0, 1'b0, 1, 1'b1, 8, -1);
    drain(1'b0, 200);
    repeat (4) @(posedge clk);
    check_errs("brk");

    // Reset in the middle of a frame: no pulses, nothing pushed.
    @(negedge clk);
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    check("mid_rst_no_push", 32'(rx_valid_a), 32'd0);
    q_a.push_back(9'h0C3);
    send(1'b0, 8, 9'h0C3, 1'b0, 1'b0, 1, 1'b1, 8, -1);
    drain(1'b0, 200);
    repeat (4) @(posedge clk);
    check_errs("rst");

    check("final_queue_a", 32'(q_a.size()), 32'd0);
    check("final_queue_b", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
